fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage with a small prefetch buffer, placed between instruction memory and the ID stage. It replaces the direct IF→ID path. It issues sequential fetch addresses, stores the fetched instructions with their return PC in a circular queue, and presents the queue head to ID. It holds the head while the hazard unit requests a hold, and flushes on a taken jump resolved in MEM.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  8  fetch address, equal to the internal fetch_pc register.
- imem_data  in  8  instruction at imem_addr; combinational read, valid in the same cycle.
- pcj_mux  in  8  jump target from MEM.
- choice_mux  in  1  1 = jump taken, redirect fetch to pcj_mux.
- stall  in  1  hazard-unit control, codebase polarity: 1 = ID consumes the head, 0 = hold.
- inst  out  8  head instruction; 8'h00 when empty.
- pc_calc  out  8  head instruction's address + 1; 8'h00 when empty.
- inst_valid  out  1  1 = queue non-empty, so inst and pc_calc are meaningful.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- State: fetch_pc (8 b), storage of DEPTH × {inst[7:0], pc_plus1[7:0]}, rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count.
- pop = stall & (count != 0).
- push = !choice_mux & ((count < DEPTH) | pop).
- On push:
  - Write {imem_data, fetch_pc+1} at wr_ptr.
  - Increment wr_ptr.
  - fetch_pc <= fetch_pc + 1, modulo 256 (8'hFF → 8'h00; the stored pc_plus1 for 8'hFF is 8'h00).
- On pop: increment rd_ptr.
- count update: count + push − pop.
- Redirect (choice_mux = 1) has priority over everything else. In that cycle:
  - No push.
  - Pop is ignored.
  - rd_ptr, wr_ptr and count are cleared to 0.
  - fetch_pc <= pcj_mux.
- No bypass. An instruction fetched in cycle N is visible at the head no earlier than cycle N+1. An empty queue never pops, even when a push happens in the same cycle.
- Outputs:
  - inst and pc_calc come directly from the storage entry at rd_ptr, gated to 0 when count = 0.
  - inst_valid = (count != 0).
  - level = count.
- Reset (async, any time, including mid-stream or mid-redirect):
  - fetch_pc = RESET_PC; pointers and count = 0; storage cleared to 0.
  - Outputs during and after reset: inst = 0, pc_calc = 0, inst_valid = 0, level = 0, imem_addr = RESET_PC.

## Timing
- Fetch-to-head latency: 1 cycle. The first edge after reset release pushes the instruction at RESET_PC, and inst_valid rises after that edge.
- Steady state with stall = 1: one push and one pop per edge; level stays at 1; one instruction per cycle reaches ID.
- With stall = 0: the queue fills at one entry per edge until level = DEPTH. It then holds; imem_addr stays at the next unfetched address.
- Full and stall = 1: push and pop happen in the same edge; level stays at DEPTH.
- Redirect, edge E:
  - After E: level = 0, inst_valid = 0, imem_addr = target.
  - After E+1: the target instruction is at the head with pc_calc = target+1.
  - choice_mux held for k cycles keeps the queue empty and re-loads fetch_pc each cycle.
- stall is sampled only at the edge. A change to stall mid-cycle has no effect until the next edge.

## Test plan
- Reset: assert reset_n = 0 mid-cycle with level = 3 → outputs immediately 0, imem_addr = 8'h00. Release and apply one edge with imem[0] = 8'hA5 → inst = 8'hA5, pc_calc = 8'h01, inst_valid = 1.
- Fill/hold: stall = 0 for 6 edges with DEPTH = 4 → level = 4 after edge 4 and stays 4; imem_addr = 8'h04; the head stays at imem[0] / pc_calc 8'h01.
- Stream: after filling, set stall = 1 for 8 edges → pc_calc sequence 1, 2, 3, …, 9; level stays 4; no instruction is lost or duplicated.
- Redirect while full with stall = 1: pulse choice_mux = 1, pcj_mux = 8'h40 → next cycle level = 0, inst_valid = 0. One edge later inst = imem[0x40], pc_calc = 8'h41.
- Wrap: redirect to 8'hFE, stall = 1 → head sequence pc_calc 8'hFF, 8'h00, 8'h01; imem_addr wraps to 8'h00.
- Bubble: empty queue, stall = 1 on the same edge as the first push → no pop; level = 1 after the edge and the head is the new instruction.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a circular prefetch queue between imem and ID.
// Sequential fetch, head presented to ID, hold on stall=0, flush on taken jump.
module fetch_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic [7:0]                 imem_addr,
  input  logic [7:0]                 imem_data,
  input  logic [7:0]                 pcj_mux,
  input  logic                       choice_mux,
  input  logic                       stall,
  output logic [7:0]                 inst,
  output logic [7:0]                 pc_calc,
  output logic                       inst_valid,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       fetch_pc;
  logic [7:0]       inst_mem [DEPTH];
  logic [7:0]       pcp_mem  [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             not_empty;
  logic             pop;
  logic             push;

  // 8-bit PC increment; wraps 8'hFF to 8'h00 naturally.
  function automatic logic [7:0] pc_inc(input logic [7:0] pc);
    return pc + 8'd1;
  endfunction

  assign not_empty = (count != '0);
  assign pop       = stall & not_empty;
  assign push      = ~choice_mux & ((count < CNT_W'(DEPTH)) | pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= 8'h00;
        pcp_mem[i]  <= 8'h00;
      end
    end else if (choice_mux) begin
      // Taken jump flushes the queue; any pop request this cycle is dropped.
      fetch_pc <= pcj_mux;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= imem_data;
        pcp_mem[wr_ptr]  <= pc_inc(fetch_pc);
        wr_ptr           <= wr_ptr + PTR_W'(1);
        fetch_pc         <= pc_inc(fetch_pc);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign imem_addr  = fetch_pc;
  assign inst       = not_empty ? inst_mem[rd_ptr] : 8'h00;
  assign pc_calc    = not_empty ? pcp_mem[rd_ptr]  : 8'h00;
  assign inst_valid = not_empty;
  assign level      = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/hold, stream, redirect, wrap, bubble.
module tb_fetch_queue;

  logic       clock;
  logic       reset_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] pcj_mux;
  logic       choice_mux;
  logic       stall;
  logic [7:0] inst;
  logic [7:0] pc_calc;
  logic       inst_valid;
  logic [2:0] level;

  int vectors;
  int miscompares;

  fetch_queue #(.DEPTH(4), .RESET_PC(8'h00)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .pcj_mux    (pcj_mux),
    .choice_mux (choice_mux),
    .stall      (stall),
    .inst       (inst),
    .pc_calc    (pc_calc),
    .inst_valid (inst_valid),
    .level      (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: imem[a] = a ^ 8'hA5 (imem[0] = 8'hA5).
  assign imem_data = imem_addr ^ 8'hA5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [7:0] pcp, input logic [2:0] lvl);
    check({tag, ".pc_calc"}, {24'h0, pc_calc}, {24'h0, pcp});
    check({tag, ".inst"}, {24'h0, inst}, {24'h0, (pcp - 8'd1) ^ 8'hA5});
    check({tag, ".valid"}, {31'h0, inst_valid}, 32'd1);
    check({tag, ".level"}, {29'h0, level}, {29'h0, lvl});
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".inst"}, {24'h0, inst}, 32'h0);
    check({tag, ".pc_calc"}, {24'h0, pc_calc}, 32'h0);
    check({tag, ".valid"}, {31'h0, inst_valid}, 32'd0);
    check({tag, ".level"}, {29'h0, level}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    stall       = 1'b0;
    choice_mux  = 1'b0;
    pcj_mux     = 8'h00;

    // Power-on reset state
    edge_step();
    edge_step();
    check_empty("por");
    check("por.addr", {24'h0, imem_addr}, 32'h00);

    // Release and build level 3, then assert reset mid-cycle
    reset_n = 1'b1;
    edge_step();
    edge_step();
    edge_step();
    check("pre_rst.level", {29'h0, level}, 32'd3);
    check("pre_rst.addr", {24'h0, imem_addr}, 32'h03);
    #2;
    reset_n = 1'b0;
    #1;
    check_empty("async_rst");
    check("async_rst.addr", {24'h0, imem_addr}, 32'h00);

    // Release; first edge pushes imem[0]
    edge_step();
    reset_n = 1'b1;
    edge_step();
    check_head("first", 8'h01, 3'd1);
    check("first.inst_a5", {24'h0, inst}, 32'hA5);

    // Fill/hold: 5 more edges with stall = 0 (6 total)
    edge_step();
    edge_step();
    edge_step();
    check("fill4.level", {29'h0, level}, 32'd4);
    edge_step();
    edge_step();
    check_head("hold", 8'h01, 3'd4);
    check("hold.addr", {24'h0, imem_addr}, 32'h04);

    // Stream while full: head pc_calc walks 1..9, level stays 4
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("stream%0d", i), 8'(i + 1), 3'd4);
      edge_step();
    end
    check_head("stream8", 8'h09, 3'd4);
    check("stream.addr", {24'h0, imem_addr}, 32'h0C);

    // Redirect while full with stall = 1
    choice_mux = 1'b1;
    pcj_mux    = 8'h40;
    edge_step();
    check_empty("redir");
    check("redir.addr", {24'h0, imem_addr}, 32'h40);
    choice_mux = 1'b0;
    // Bubble: empty queue with stall = 1 on the first push edge
    edge_step();
    check_head("redir_tgt", 8'h41, 3'd1);
    check("redir_tgt.inst_e5", {24'h0, inst}, 32'hE5);
    edge_step();
    check_head("redir_next", 8'h42, 3'd1);

    // Wrap through 8'hFF
    choice_mux = 1'b1;
    pcj_mux    = 8'hFE;
    edge_step();
    choice_mux = 1'b0;
    edge_step();
    check_head("wrap0", 8'hFF, 3'd1);
    check("wrap0.addr", {24'h0, imem_addr}, 32'hFF);
    edge_step();
    check_head("wrap1", 8'h00, 3'd1);
    check("wrap1.addr", {24'h0, imem_addr}, 32'h00);
    edge_step();
    check_head("wrap2", 8'h01, 3'd1);
    check("wrap2.addr", {24'h0, imem_addr}, 32'h01);

    // Held redirect reloads fetch_pc each cycle and keeps queue empty
    choice_mux = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pcj_mux = 8'(8'h10 * (k + 1));
      edge_step();
      check_empty($sformatf("hold_redir%0d", k));
      check($sformatf("hold_redir%0d.addr", k), {24'h0, imem_addr}, 32'(8'h10 * (k + 1)));
    end
    choice_mux = 1'b0;
    stall      = 1'b0;
    edge_step();
    check_head("after_hold", 8'h31, 3'd1);
    edge_step();
    check_head("after_hold2", 8'h31, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
